// File: rtl/sync_mon_pkg.sv
// Shared types and widths for the sync mode monitor and its helpers.
package sync_mon_pkg;

  localparam int unsigned VT_W = 11;
  localparam int unsigned PF_W = 20;

  typedef enum logic [1:0] {
    NOSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    STABLE  = 2'd2
  } mon_state_e;

  // One bit wider than the operands so the difference never wraps.
  function automatic logic [PF_W:0] pf_abs_diff(input logic [PF_W-1:0] a,
                                                input logic [PF_W-1:0] b);
    logic [PF_W:0] wa;
    logic [PF_W:0] wb;
    wa = {1'b0, a};
    wb = {1'b0, b};
    return (wa >= wb) ? (wa - wb) : (wb - wa);
  endfunction

endpackage

// File: rtl/mon_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_CYCLES clocks.
module mon_tick_gen #(
  parameter int unsigned TICK_CYCLES = 27000
) (
  input  logic CLK_i,
  input  logic reset_n,
  output logic tick_o
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [CW-1:0] tick_ctr;

  assign tick_o = (tick_ctr == CW'(TICK_CYCLES - 1));

  always_ff @(posedge CLK_i or negedge reset_n) begin
    if (!reset_n) begin
      tick_ctr <= '0;
    end else if (tick_o) begin
      tick_ctr <= '0;
    end else begin
      tick_ctr <= tick_ctr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_mode_monitor.sv
// Debounces frontend sync measurements into a stable mode record and raises
// a sticky interrupt whenever that mode is acquired, changes or is lost.
module sync_mode_monitor
  import sync_mon_pkg::*;
#(
  parameter int unsigned TICK_CYCLES    = 27000,
  parameter int unsigned STABLE_TICKS   = 8,
  parameter int unsigned UNSTABLE_TICKS = 3,
  parameter int unsigned PCNT_TOL       = 64
) (
  input  logic            CLK_MEAS_i,
  input  logic            reset_n,
  input  logic            sync_active_i,
  input  logic [VT_W-1:0] vtotal_i,
  input  logic [PF_W-1:0] pcnt_frame_i,
  input  logic            interlace_i,
  input  logic            irq_ack_i,
  output logic            mode_valid_o,
  output logic [VT_W-1:0] mode_vtotal_o,
  output logic [PF_W-1:0] mode_pcnt_frame_o,
  output logic            mode_interlace_o,
  output logic [1:0]      state_o,
  output logic            irq_o,
  output logic [7:0]      change_cnt_o
);

  localparam int unsigned DW = PF_W + 1;

  if (STABLE_TICKS == 0 || STABLE_TICKS > 15 ||
      UNSTABLE_TICKS == 0 || UNSTABLE_TICKS > 15) begin : g_bad_ticks
    $error("STABLE_TICKS and UNSTABLE_TICKS must be in 1..15");
  end

  logic tick;

  mon_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .CLK_i   (CLK_MEAS_i),
    .reset_n (reset_n),
    .tick_o  (tick)
  );

  logic            sa_q, il_q, ack_q;
  logic [VT_W-1:0] vt_q;
  logic [PF_W-1:0] pf_q;

  always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
    if (!reset_n) begin
      sa_q  <= 1'b0;
      il_q  <= 1'b0;
      ack_q <= 1'b0;
      vt_q  <= '0;
      pf_q  <= '0;
    end else begin
      sa_q  <= sync_active_i;
      il_q  <= interlace_i;
      ack_q <= irq_ack_i;
      vt_q  <= vtotal_i;
      pf_q  <= pcnt_frame_i;
    end
  end

  mon_state_e      state_q, state_d;
  logic [3:0]      stable_q, stable_d, mis_q, mis_d;
  logic [VT_W-1:0] ref_vt_q, ref_vt_d, mvt_q, mvt_d;
  logic [PF_W-1:0] ref_pf_q, ref_pf_d, mpf_q, mpf_d;
  logic            ref_il_q, ref_il_d, mil_q, mil_d;
  logic            valid_q, valid_d, irq_q, irq_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            evt, match;

  assign match = (vt_q == ref_vt_q) && (il_q == ref_il_q) &&
                 (pf_abs_diff(pf_q, ref_pf_q) <= DW'(PCNT_TOL));

  always_ff @(posedge CLK_MEAS_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= NOSYNC;
      stable_q <= '0;
      mis_q    <= '0;
      ref_vt_q <= '0;
      ref_pf_q <= '0;
      ref_il_q <= 1'b0;
      mvt_q    <= '0;
      mpf_q    <= '0;
      mil_q    <= 1'b0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      mis_q    <= mis_d;
      ref_vt_q <= ref_vt_d;
      ref_pf_q <= ref_pf_d;
      ref_il_q <= ref_il_d;
      mvt_q    <= mvt_d;
      mpf_q    <= mpf_d;
      mil_q    <= mil_d;
      valid_q  <= valid_d;
      irq_q    <= irq_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    mis_d    = mis_q;
    ref_vt_d = ref_vt_q;
    ref_pf_d = ref_pf_q;
    ref_il_d = ref_il_q;
    mvt_d    = mvt_q;
    mpf_d    = mpf_q;
    mil_d    = mil_q;
    valid_d  = valid_q;
    evt      = 1'b0;

    unique case (state_q)
      NOSYNC: begin
        if (sa_q) begin
          state_d  = ACQUIRE;
          ref_vt_d = vt_q;
          ref_pf_d = pf_q;
          ref_il_d = il_q;
          stable_d = '0;
        end
      end
      ACQUIRE: begin
        if (!sa_q) begin
          state_d  = NOSYNC;
          valid_d  = 1'b0;
          stable_d = '0;
          mis_d    = '0;
        end else if (tick) begin
          if (match) begin
            if (stable_q == 4'(STABLE_TICKS - 1)) begin
              state_d  = STABLE;
              mvt_d    = ref_vt_q;
              mpf_d    = ref_pf_q;
              mil_d    = ref_il_q;
              valid_d  = 1'b1;
              stable_d = '0;
              mis_d    = '0;
              evt      = 1'b1;
            end else begin
              stable_d = stable_q + 4'd1;
            end
          end else begin
            ref_vt_d = vt_q;
            ref_pf_d = pf_q;
            ref_il_d = il_q;
            stable_d = '0;
          end
        end
      end
      STABLE: begin
        if (!sa_q) begin
          state_d  = NOSYNC;
          valid_d  = 1'b0;
          stable_d = '0;
          mis_d    = '0;
          evt      = 1'b1;
        end else if (tick) begin
          if (match) begin
            mis_d = '0;
          end else if (mis_q == 4'(UNSTABLE_TICKS - 1)) begin
            state_d  = ACQUIRE;
            valid_d  = 1'b0;
            ref_vt_d = vt_q;
            ref_pf_d = pf_q;
            ref_il_d = il_q;
            stable_d = '0;
            mis_d    = '0;
            evt      = 1'b1;
          end else begin
            mis_d = mis_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = NOSYNC;
      end
    endcase
  end

  // A new event wins over a coincident acknowledge.
  assign irq_d = evt | (irq_q & ~ack_q);
  assign cnt_d = (evt && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;

  assign mode_valid_o      = valid_q;
  assign mode_vtotal_o     = mvt_q;
  assign mode_pcnt_frame_o = mpf_q;
  assign mode_interlace_o  = mil_q;
  assign state_o           = state_q;
  assign irq_o             = irq_q;
  assign change_cnt_o      = cnt_q;

endmodule

// File: tb/tb_sync_mode_monitor.sv
// Directed and randomized checks of sync_mode_monitor against a cycle model.
module tb_sync_mode_monitor;

  localparam int TICK     = 16;
  localparam int S_TICKS  = 8;
  localparam int U_TICKS  = 3;
  localparam int TOL      = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sa = 1'b0;
  logic [10:0] vt = '0;
  logic [19:0] pf = '0;
  logic        il = 1'b0;
  logic        ack = 1'b0;

  logic        mode_valid, mode_il, irq;
  logic [10:0] mode_vt;
  logic [19:0] mode_pf;
  logic [1:0]  state;
  logic [7:0]  cnt;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  sync_mode_monitor #(
    .TICK_CYCLES(TICK),
    .STABLE_TICKS(S_TICKS),
    .UNSTABLE_TICKS(U_TICKS),
    .PCNT_TOL(TOL)
  ) dut (
    .CLK_MEAS_i(clk),
    .reset_n(rst_n),
    .sync_active_i(sa),
    .vtotal_i(vt),
    .pcnt_frame_i(pf),
    .interlace_i(il),
    .irq_ack_i(ack),
    .mode_valid_o(mode_valid),
    .mode_vtotal_o(mode_vt),
    .mode_pcnt_frame_o(mode_pf),
    .mode_interlace_o(mode_il),
    .state_o(state),
    .irq_o(irq),
    .change_cnt_o(cnt)
  );

  // Reference model: inputs seen one edge late; "run" counts consecutive
  // matching ticks while acquiring, "bad" consecutive mismatching ticks.
  int m_phase, m_state, m_run, m_bad, m_valid, m_irq, m_cnt;
  int m_rvt, m_rpf, m_ril, m_mvt, m_mpf, m_mil;
  int r_sa, r_vt, r_pf, r_il, r_ack;

  function automatic void model_reset();
    m_phase = 0; m_state = 0; m_run = 0; m_bad = 0; m_valid = 0;
    m_irq = 0; m_cnt = 0; m_rvt = 0; m_rpf = 0; m_ril = 0;
    m_mvt = 0; m_mpf = 0; m_mil = 0;
    r_sa = 0; r_vt = 0; r_pf = 0; r_il = 0; r_ack = 0;
  endfunction

  function automatic void model_edge();
    bit tk, ev, mt;
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = (m_phase == TICK - 1);
    m_phase = (m_phase + 1) % TICK;
    d = (r_pf > m_rpf) ? r_pf - m_rpf : m_rpf - r_pf;
    mt = (r_vt == m_rvt) && (r_il == m_ril) && (d <= TOL);
    ev = 0;
    if (m_state == 0) begin
      if (r_sa != 0) begin
        m_state = 1; m_run = 0;
        m_rvt = r_vt; m_rpf = r_pf; m_ril = r_il;
      end
    end else if (r_sa == 0) begin
      if (m_state == 2) ev = 1;
      m_state = 0; m_valid = 0; m_run = 0; m_bad = 0;
    end else if (tk && m_state == 1) begin
      if (mt) begin
        m_run++;
        if (m_run == S_TICKS) begin
          m_state = 2; m_valid = 1; ev = 1; m_run = 0; m_bad = 0;
          m_mvt = m_rvt; m_mpf = m_rpf; m_mil = m_ril;
        end
      end else begin
        m_run = 0; m_rvt = r_vt; m_rpf = r_pf; m_ril = r_il;
      end
    end else if (tk) begin
      if (mt) m_bad = 0;
      else begin
        m_bad++;
        if (m_bad == U_TICKS) begin
          m_state = 1; m_valid = 0; ev = 1; m_run = 0; m_bad = 0;
          m_rvt = r_vt; m_rpf = r_pf; m_ril = r_il;
        end
      end
    end
    if (ev) m_irq = 1;
    else if (r_ack != 0) m_irq = 0;
    if (ev && m_cnt < 255) m_cnt++;
    r_sa = int'(sa); r_vt = int'(vt); r_pf = int'(pf); r_il = int'(il); r_ack = int'(ack);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [63:0] o, e;
    @(negedge clk);
    model_edge();
    o = {20'd0, state, mode_valid, mode_vt, mode_pf, mode_il, irq, cnt};
    e = {20'd0, 2'(m_state), 1'(m_valid), 11'(m_mvt), 20'(m_mpf), 1'(m_mil),
         1'(m_irq), 8'(m_cnt)};
    chk("model_outputs", o, e);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  function automatic logic [19:0] jit(input int centre, input int span);
    return 20'(centre + int'($urandom_range(0, 2 * span)) - span);
  endfunction

  initial begin
    int n;
    model_reset();
    sa = 1'b1; vt = 11'd525; pf = 20'd450450; il = 1'b0;
    #1;
    chk("reset_state", {62'd0, state}, 64'd0);
    chk("reset_irq_cnt", {55'd0, irq, cnt}, 64'd0);
    chk("reset_valid", {63'd0, mode_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: acquire a constant mode
    steps(2);
    chk("t1_acquire", {62'd0, state}, 64'd1);
    steps(200);
    chk("t1_stable", {62'd0, state}, 64'd2);
    chk("t1_valid", {63'd0, mode_valid}, 64'd1);
    chk("t1_vtotal", {53'd0, mode_vt}, 64'd525);
    chk("t1_pcnt", {44'd0, mode_pf}, 64'd450450);
    chk("t1_irq", {63'd0, irq}, 64'd1);
    chk("t1_cnt", {56'd0, cnt}, 64'd1);

    // 2: jitter within tolerance, then tolerance boundaries
    for (int i = 0; i < 160; i++) begin
      pf = jit(450450, TOL);
      step();
    end
    pf = 20'd450514; steps(16);
    pf = 20'd450515; steps(16);
    pf = 20'd450450; steps(16);
    chk("t2_stable", {62'd0, state}, 64'd2);
    chk("t2_irq", {63'd0, irq}, 64'd1);
    chk("t2_cnt", {56'd0, cnt}, 64'd1);

    // 3: mode change
    pulse_ack();
    steps(2);
    chk("t3_irq_acked", {63'd0, irq}, 64'd0);
    vt = 11'd625;
    n = 0;
    while (state == 2'd2 && n < 100) begin
      pf = jit(540000, 20);
      step();
      n++;
    end
    chk("t3_leave_state", {62'd0, state}, 64'd1);
    chk("t3_leave_valid", {63'd0, mode_valid}, 64'd0);
    chk("t3_leave_irq", {63'd0, irq}, 64'd1);
    for (int i = 0; i < 200; i++) begin
      pf = jit(540000, 20);
      step();
    end
    chk("t3_stable", {62'd0, state}, 64'd2);
    chk("t3_vtotal", {53'd0, mode_vt}, 64'd625);
    chk("t3_cnt", {56'd0, cnt}, 64'd3);

    // 4: isolated mismatches never accumulate to a change
    pf = 20'd540000;
    pulse_ack();
    steps(2);
    vt = 11'd624; steps(32);
    vt = 11'd625; steps(16);
    vt = 11'd624; steps(32);
    vt = 11'd625; steps(32);
    chk("t4_stable", {62'd0, state}, 64'd2);
    chk("t4_irq", {63'd0, irq}, 64'd0);
    chk("t4_cnt", {56'd0, cnt}, 64'd3);

    // 5: sync loss in STABLE, then in ACQUIRE
    sa = 1'b0;
    steps(2);
    chk("t5_nosync", {62'd0, state}, 64'd0);
    chk("t5_valid", {63'd0, mode_valid}, 64'd0);
    chk("t5_irq", {63'd0, irq}, 64'd1);
    chk("t5_cnt", {56'd0, cnt}, 64'd4);
    sa = 1'b1;
    pulse_ack();
    steps(40);
    chk("t5_acq", {62'd0, state}, 64'd1);
    sa = 1'b0;
    steps(2);
    chk("t5_acq_loss", {62'd0, state}, 64'd0);
    chk("t5_acq_loss_irq", {63'd0, irq}, 64'd0);
    chk("t5_acq_loss_cnt", {56'd0, cnt}, 64'd4);

    // 6: ack coincident with STABLE entry
    sa = 1'b1;
    n = 0;
    while (!(m_state == 1 && m_run == S_TICKS - 1 && m_phase == TICK - 2) && n < 300) begin
      step();
      n++;
    end
    chk("t6_align_timeout", {63'd0, n < 300}, 64'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk("t6_entry_state", {62'd0, state}, 64'd2);
    chk("t6_entry_irq", {63'd0, irq}, 64'd1);
    steps(3);
    chk("t6_irq_held", {63'd0, irq}, 64'd1);
    pulse_ack();
    steps(2);
    chk("t6_lone_ack", {63'd0, irq}, 64'd0);

    // randomized phase: slow mode changes, jitter, sync glitches, acks
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 63) == 0) vt = 11'(524 + $urandom_range(0, 2));
      if ($urandom_range(0, 127) == 0) il = ~il;
      if ($urandom_range(0, 199) == 0) sa = ~sa;
      else if (!sa && $urandom_range(0, 7) == 0) sa = 1'b1;
      pf = jit(450450, 90);
      ack = ($urandom_range(0, 31) == 0);
      step();
    end
    ack = 1'b0;

    // reset in the middle of ACQUIRE
    sa = 1'b0; steps(3);
    sa = 1'b1; steps(20);
    chk("t6_pre_reset", {62'd0, state}, 64'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", {62'd0, state}, 64'd0);
    chk("rst_outputs", {22'd0, mode_valid, mode_vt, mode_pf, mode_il, irq, cnt}, 64'd0);
    steps(3);
    rst_n = 1'b1;
    steps(5);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
